// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Drain engine for the read side of the byte FIFO. Bytes are popped one at a
// time from the FIFO read port and offered on a valid/ready transmit
// interface. A one-cycle packet-end strobe closes the packet after every
// BURST_LEN accepted bytes, or on a flush request once the FIFO is empty.
//
// Ports:
//   rdclk      in   single clock, shared with the FIFO read port
//   reset      in   synchronous, active-high reset
//   fifo_rden  out  FIFO pop request (combinational, never while reset)
//   fifo_dout  in   FIFO data, valid the cycle after a pop
//   fifo_empty in   FIFO empty flag
//   flush      in   level request to close a partial packet once drained
//   tx_data    out  byte offered to the sink
//   tx_valid   out  tx_data holds a byte
//   tx_ready   in   sink accepts tx_data on a rising edge with tx_valid high
//   tx_pktend  out  one-cycle strobe closing the current packet
//   pkt_bytes  out  bytes accepted in the currently open packet
//   busy       out  registered, high whenever the FSM is not in IDLE
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing in flight; pop if FIFO has data, else honour flush
// FETCH   | popped byte is on fifo_dout; latch it into tx_data
// SEND    | byte offered on tx_data/tx_valid, waiting for tx_ready
// PKTEND  | tx_pktend high for this single cycle; packet count cleared

module fifo_stream_reader #(
  parameter int unsigned BURST_LEN = 64
) (
  input  logic        rdclk,
  input  logic        reset,
  output logic        fifo_rden,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        flush,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_pktend,
  output logic [15:0] pkt_bytes,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    PKTEND = 2'd3
  } state_t;

  // 17-bit compare so BURST_LEN = 65535 never wraps the incremented count.
  localparam logic [16:0] BURST_CNT = 17'(BURST_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        pop;
  logic        accept;
  logic        burst_done;
  logic [16:0] pkt_bytes_inc;

  assign pkt_bytes_inc = {1'b0, pkt_bytes} + 17'd1;
  assign burst_done    = (pkt_bytes_inc == BURST_CNT);

  // tx_valid is always high while in SEND, so ready alone marks acceptance.
  assign accept = (state == SEND) && tx_ready;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = FETCH;
        end else if (flush && (pkt_bytes != 16'd0)) begin
          state_nxt = PKTEND;
        end
      end
      FETCH: begin
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          if (burst_done) begin
            state_nxt = PKTEND;
          end else if (!fifo_empty) begin
            // Back-to-back pop on the acceptance edge keeps 1 byte / 2 cycles.
            pop       = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      PKTEND: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset gates the pop so the FIFO is never drained while we are held.
  assign fifo_rden = pop && !reset;

  always_ff @(posedge rdclk) begin
    if (reset) begin
      state     <= IDLE;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      tx_pktend <= 1'b0;
      pkt_bytes <= 16'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      tx_pktend <= (state_nxt == PKTEND);

      if (state == FETCH) begin
        tx_data  <= fifo_dout;
        tx_valid <= 1'b1;
      end

      if (accept) begin
        tx_valid  <= 1'b0;
        pkt_bytes <= pkt_bytes_inc[15:0];
      end

      if (state == PKTEND) begin
        pkt_bytes <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: directed scenarios plus a random phase.
// The stimulus process owns a FIFO model and an expected-byte queue; an
// independent monitor tracks the packet model and checks every accepted byte.

module tb_fifo_stream_reader;

  localparam int BURST_LEN = 4;

  logic        rdclk = 1'b0;
  logic        reset;
  logic        fifo_rden;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        flush;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_pktend;
  logic [15:0] pkt_bytes;
  logic        busy;

  fifo_stream_reader #(.BURST_LEN(BURST_LEN)) dut (
    .rdclk      (rdclk),
    .reset      (reset),
    .fifo_rden  (fifo_rden),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .flush      (flush),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_pktend  (tx_pktend),
    .pkt_bytes  (pkt_bytes),
    .busy       (busy)
  );

  always #5 rdclk = ~rdclk;

  int errors = 0;
  int checks = 0;

  byte unsigned fifo_q[$];
  byte unsigned exp_mem[$];
  logic         rden_s;

  // monitor-owned model state (read by stimulus, never written there)
  int   rd_idx     = 0;
  int   open_cnt   = 0;
  int   pktend_cnt = 0;
  int   acc_cnt    = 0;
  logic exp_full   = 1'b0;
  logic flush_prev = 1'b0;
  logic hold_prev  = 1'b0;
  logic [7:0] data_prev = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input byte unsigned b);
    fifo_q.push_back(b);
    exp_mem.push_back(b);
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    fifo_empty = (fifo_q.size() == 0);
    #2;
    check("no_overread", 32'(fifo_rden & (reset | fifo_empty)), 32'd0);
    rden_s = fifo_rden;
    @(posedge rdclk);
    #1;
    if (rden_s === 1'b1 && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge rdclk);
  endtask

  task automatic drain();
    int n;
    tx_ready = 1'b1;
    repeat (2) cycle();
    n = 0;
    while ((busy !== 1'b0 || fifo_q.size() != 0) && n < 100) begin
      cycle();
      n++;
    end
    check("drain_done", 32'(n < 100), 32'd1);
  endtask

  // Monitor: samples just before each rising edge, inputs already stable.
  initial begin : monitor
    forever begin
      @(negedge rdclk);
      #3;
      if (reset === 1'b1) begin
        // A byte held on the interface at reset is lost with the FSM state.
        if (tx_valid === 1'b1) rd_idx++;
        open_cnt   = 0;
        exp_full   = 1'b0;
        flush_prev = 1'b0;
        hold_prev  = 1'b0;
      end else begin
        check("pkt_bytes", 32'(pkt_bytes), 32'(open_cnt));
        if (exp_full) check("pktend_after_full", 32'(tx_pktend), 32'd1);
        check("pktend_with_valid", 32'(tx_pktend & tx_valid), 32'd0);
        if (tx_pktend === 1'b1) begin
          check("pktend_legal", 32'(exp_full || (flush_prev && open_cnt > 0)), 32'd1);
          pktend_cnt++;
          open_cnt = 0;
          exp_full = 1'b0;
        end
        if (hold_prev) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(data_prev));
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b0)
          check("no_pop_while_held", 32'(fifo_rden), 32'd0);
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
          check("byte_expected", 32'(rd_idx < exp_mem.size()), 32'd1);
          if (rd_idx < exp_mem.size())
            check("tx_data", 32'(tx_data), 32'(exp_mem[rd_idx]));
          rd_idx++;
          acc_cnt++;
          open_cnt++;
          if (open_cnt == BURST_LEN) exp_full = 1'b1;
        end
        flush_prev = flush && fifo_empty && (open_cnt > 0);
        hold_prev  = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        data_prev  = tx_data;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int valid_at[$];
    int pk_at;
    int n;
    int a0;
    int c0;

    reset      = 1'b1;
    flush      = 1'b0;
    tx_ready   = 1'b0;
    fifo_dout  = 8'h00;
    fifo_empty = 1'b1;
    rden_s     = 1'b0;

    // Reset held 3 cycles with the FIFO pre-loaded.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_pktend", 32'(tx_pktend), 32'd0);
      check("rst_pkt_bytes", 32'(pkt_bytes), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_fifo_kept", 32'(fifo_q.size()), 32'd4);

    // Basic transfer: one byte per 2 cycles, strobe after the 4th.
    reset    = 1'b0;
    tx_ready = 1'b1;
    pk_at    = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (tx_valid === 1'b1) valid_at.push_back(k);
      if (tx_pktend === 1'b1 && pk_at == 0) pk_at = k;
    end
    check("basic_nbytes", 32'(valid_at.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < valid_at.size()) check("basic_valid_cycle", 32'(valid_at[i]), 32'(2 * (i + 1)));
    check("basic_pktend_cycle", 32'(pk_at), 32'd9);
    check("basic_pkt_bytes_after", 32'(pkt_bytes), 32'd0);

    // Backpressure: 0xA5 held for 10 cycles, then a single acceptance.
    tx_ready = 1'b0;
    push(8'hA5);
    n = 0;
    while (tx_valid !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    check("bp_latency", 32'(n), 32'd2);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'hA5);
    end
    a0 = acc_cnt;
    tx_ready = 1'b1;
    cycle();
    tx_ready = 1'b0;
    cycle();
    cycle();
    check("bp_single_accept", 32'(acc_cnt - a0), 32'd1);
    check("bp_valid_low", 32'(tx_valid), 32'd0);

    // Flush of a partial packet (3 of 4 bytes), then a flush with nothing open.
    push(8'h01); push(8'h02);
    drain();
    check("flush_pkt_bytes_before", 32'(pkt_bytes), 32'd3);
    c0 = pktend_cnt;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_pktend", 32'(tx_pktend), 32'd1);
    cycle();
    check("flush_pkt_bytes_after", 32'(pkt_bytes), 32'd0);
    check("flush_one_strobe", 32'(pktend_cnt - c0), 32'd1);
    c0 = pktend_cnt;
    flush = 1'b1;
    repeat (3) cycle();
    flush = 1'b0;
    cycle();
    check("flush_empty_no_strobe", 32'(pktend_cnt - c0), 32'd0);

    // FIFO empties mid-burst, refills 3 cycles later; count carries on.
    tx_ready = 1'b1;
    push(8'h61); push(8'h62);
    repeat (6) cycle();
    check("mid_idle_busy", 32'(busy), 32'd0);
    check("mid_pkt_bytes", 32'(pkt_bytes), 32'd2);
    repeat (3) cycle();
    c0 = pktend_cnt;
    push(8'h63); push(8'h64); push(8'h65);
    repeat (12) cycle();
    check("mid_pktend", 32'(pktend_cnt - c0), 32'd1);
    check("mid_pkt_bytes_resume", 32'(pkt_bytes), 32'd1);

    // Reset while a byte is held in SEND.
    tx_ready = 1'b0;
    push(8'h5A);
    n = 0;
    while (tx_valid !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check("rw_valid_before", 32'(tx_valid), 32'd1);
    a0 = acc_cnt;
    reset = 1'b1;
    cycle();
    check("rw_valid_low", 32'(tx_valid), 32'd0);
    check("rw_pkt_bytes", 32'(pkt_bytes), 32'd0);
    reset    = 1'b0;
    tx_ready = 1'b1;
    repeat (10) cycle();
    check("rw_no_accept", 32'(acc_cnt - a0), 32'd0);
    check("rw_idle", 32'(busy), 32'd0);

    // Random traffic, backpressure and flush requests.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) push(8'($urandom));
      tx_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      cycle();
    end
    flush = 1'b0;
    drain();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (3) cycle();
    check("all_bytes_delivered", 32'(rd_idx), 32'(exp_mem.size()));
    check("final_pkt_bytes", 32'(pkt_bytes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
